// File: rtl/seg_dec_pkg.sv
// Shared constants for the scanned 7-segment receive path: digit count,
// active-low segment patterns {g..a} and the scan FSM state type.
package seg_dec_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD
    } scan_state_t;

    // True when exactly one select line is pulled low.
    function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] sel);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational segment-pattern decoder: 7-bit active-low {g..a} to value.
// Hex letters A-F are only accepted when SEG_DEC_HEX_EN is defined.
module seg_pattern_dec
    import seg_dec_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic       blank,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        value = 4'h0;
        case (pattern)
            SEG_0:     value = 4'h0;
            SEG_1:     value = 4'h1;
            SEG_2:     value = 4'h2;
            SEG_3:     value = 4'h3;
            SEG_4:     value = 4'h4;
            SEG_5:     value = 4'h5;
            SEG_6:     value = 4'h6;
            SEG_7:     value = 4'h7;
            SEG_8:     value = 4'h8;
            SEG_9:     value = 4'h9;
`ifdef SEG_DEC_HEX_EN
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
`endif
            SEG_BLANK: blank = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a 6-digit multiplexed 7-segment bus: samples each
// settled digit, assembles frames and reports after FRAME_MATCH repeats.
// Optional hex letter decode is enabled by defining SEG_DEC_HEX_EN.
module seg_scan_decoder
    import seg_dec_pkg::*;
#(
    parameter int SETTLE_CYC  = 8,
    parameter int FRAME_MATCH = 2,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   seg_sel,
    input  logic [7:0]              seg_led,
    output logic [4*NUM_DIGITS-1:0] num,
    output logic                    en,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic                    num_valid,
    output logic                    err,
    output logic                    stale
);

    logic [NUM_DIGITS-1:0]   sel_meta, sel_sync, sel_cur;
    logic [7:0]              led_meta, led_sync;
    scan_state_t             state, state_nxt;
    logic [7:0]              settle_cnt;
    logic [21:0]             timeout_cnt;
    logic                    timeout_hit;
    logic                    dec_legal, dec_blank;
    logic [3:0]              dec_value;
    logic [NUM_DIGITS-1:0]   mask, work_blank, work_dp, prev_blank, prev_dp;
    logic [4*NUM_DIGITS-1:0] work_num, prev_num;
    logic [3:0]              match_cnt, match_nxt;
    logic                    frame_equal;

    // Idle bus level is all-high, so the synchroniser resets to "nothing selected".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_meta <= '1;
            sel_sync <= '1;
            led_meta <= '1;
            led_sync <= '1;
        end else begin
            sel_meta <= seg_sel;
            sel_sync <= sel_meta;
            led_meta <= seg_led;
            led_sync <= led_meta;
        end
    end

    seg_pattern_dec u_pattern_dec (
        .pattern (led_sync[6:0]),
        .legal   (dec_legal),
        .blank   (dec_blank),
        .value   (dec_value)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (one_hot_low(sel_sync)) state_nxt = SETTLE;
            SETTLE: begin
                if (sel_sync != sel_cur)
                    state_nxt = IDLE;
                else if (settle_cnt == 8'(SETTLE_CYC - 1))
                    state_nxt = SAMPLE;
            end
            SAMPLE: state_nxt = HOLD;
            HOLD: begin
                if (sel_sync != sel_cur)
                    state_nxt = one_hot_low(sel_sync) ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = IDLE;
    end

    // sel_cur latches the digit being settled; the counter restarts on each entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_cur    <= '1;
            settle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == SETTLE && state != SETTLE) begin
                sel_cur    <= sel_sync;
                settle_cnt <= '0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 8'd1;
            end
        end
    end

    assign timeout_hit = (state != SAMPLE) && (timeout_cnt == 22'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_cnt <= '0;
        else if (state == SAMPLE)
            timeout_cnt <= '0;
        else if (timeout_cnt != 22'(TIMEOUT_CYC))
            timeout_cnt <= timeout_cnt + 22'd1;
    end

    assign err = (state == SAMPLE) && !dec_legal;

    assign frame_equal = (work_num == prev_num) && (work_blank == prev_blank) &&
                         (work_dp == prev_dp);

    always_comb begin
        if (!frame_equal)
            match_nxt = 4'd1;
        else if (match_cnt == 4'hF)
            match_nxt = 4'hF;
        else
            match_nxt = match_cnt + 4'd1;
    end

    // Frame assembly; a completed frame is evaluated in the cycle after its last
    // digit lands, which can never coincide with another SAMPLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask       <= '0;
            work_num   <= '0;
            work_blank <= '0;
            work_dp    <= '0;
            prev_num   <= '0;
            prev_blank <= '0;
            prev_dp    <= '0;
            match_cnt  <= '0;
            num        <= '0;
            en         <= 1'b0;
            dp         <= '0;
            num_valid  <= 1'b0;
            stale      <= 1'b1;
        end else begin
            num_valid <= 1'b0;
            if (timeout_hit) begin
                mask      <= '0;
                match_cnt <= '0;
                stale     <= 1'b1;
            end else if (state == SAMPLE) begin
                if (dec_legal) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (!sel_cur[k]) begin
                            work_num[4*k +: 4] <= dec_value;
                            work_blank[k]      <= dec_blank;
                            work_dp[k]         <= ~led_sync[7];
                            mask[k]            <= 1'b1;
                        end
                    end
                end else begin
                    match_cnt <= '0;
                end
            end else if (mask == '1) begin
                match_cnt  <= match_nxt;
                prev_num   <= work_num;
                prev_blank <= work_blank;
                prev_dp    <= work_dp;
                mask       <= '0;
                if (match_nxt >= 4'(FRAME_MATCH)) begin
                    num       <= work_num;
                    en        <= |(~work_blank);
                    dp        <= work_dp;
                    num_valid <= 1'b1;
                    stale     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table-driven frames, hand-built
// corner sequences and randomized scans against a transaction-level model.
module tb_seg_scan_decoder;

    localparam int SETTLE    = 8;
    localparam int MATCH     = 2;
    localparam int TMO       = 1000;
    localparam int DIGIT_CYC = 20;
`ifdef SEG_DEC_HEX_EN
    localparam bit HEX_OK = 1'b1;
`else
    localparam bit HEX_OK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  seg_sel = 6'h3F;
    logic [7:0]  seg_led = 8'hFF;
    logic [23:0] num;
    logic        en;
    logic [5:0]  dp;
    logic        num_valid;
    logic        err;
    logic        stale;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .SETTLE_CYC  (SETTLE),
        .FRAME_MATCH (MATCH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_sel   (seg_sel),
        .seg_led   (seg_led),
        .num       (num),
        .en        (en),
        .dp        (dp),
        .num_valid (num_valid),
        .err       (err),
        .stale     (stale)
    );

    typedef struct packed {
        logic [23:0] num;
        logic        en;
        logic [5:0]  dp;
    } rep_t;

    typedef struct {
        logic [47:0] pats;
        int          frames;
        int          exp_valids;
        logic [23:0] exp_num;
        logic        exp_en;
        logic [5:0]  exp_dp;
        int          exp_errs;
        logic        exp_stale;
    } vec_t;

    int         check_count = 0;
    int         err_count   = 0;
    int         obs_valids  = 0;
    int         obs_errs    = 0;
    rep_t       exp_q[$];
    logic [6:0] seg_tab[16];

    // Reference model: the frame as a set of captured digits plus repeat count.
    logic [3:0] m_val[6];
    logic       m_blank[6], m_dp[6], m_have[6];
    logic [3:0] p_val[6];
    logic       p_blank[6], p_dp[6];
    int         m_match, m_errs, m_valids;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic decodeRef(input logic [6:0] p, output logic legal, output logic blank,
                             output logic [3:0] v);
        legal = 1'b0;
        blank = 1'b0;
        v     = 4'h0;
        if (p == 7'h7F) begin
            legal = 1'b1;
            blank = 1'b1;
        end else begin
            for (int d = 0; d < 16; d++) begin
                if (seg_tab[d] == p && (HEX_OK || d < 10)) begin
                    legal = 1'b1;
                    v     = 4'(d);
                end
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 6; i++) begin
            m_val[i] = 0; m_blank[i] = 0; m_dp[i] = 0; m_have[i] = 0;
            p_val[i] = 0; p_blank[i] = 0; p_dp[i] = 0;
        end
        m_match = 0; m_errs = 0; m_valids = 0;
        exp_q.delete();
        obs_valids = 0;
        obs_errs   = 0;
    endtask

    task automatic modelTimeout();
        for (int i = 0; i < 6; i++) m_have[i] = 0;
        m_match = 0;
    endtask

    task automatic modelCapture(input int k, input logic [7:0] pat);
        logic       legal, blank, same, full;
        logic [3:0] v;
        rep_t       r;
        decodeRef(pat[6:0], legal, blank, v);
        if (!legal) begin
            m_errs++;
            m_match = 0;
            return;
        end
        m_val[k] = v; m_blank[k] = blank; m_dp[k] = ~pat[7]; m_have[k] = 1'b1;
        full = 1'b1;
        same = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!m_have[i]) full = 1'b0;
            if (m_val[i] != p_val[i] || m_blank[i] != p_blank[i] || m_dp[i] != p_dp[i])
                same = 1'b0;
        end
        if (!full) return;
        m_match = !same ? 1 : (m_match < 15 ? m_match + 1 : 15);
        r = '0;
        for (int i = 0; i < 6; i++) begin
            p_val[i] = m_val[i]; p_blank[i] = m_blank[i]; p_dp[i] = m_dp[i];
            m_have[i] = 1'b0;
            r.num[4*i +: 4] = m_val[i];
            r.dp[i] = m_dp[i];
            if (!m_blank[i]) r.en = 1'b1;
        end
        if (m_match >= MATCH) begin
            exp_q.push_back(r);
            m_valids++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (num_valid && err) checkOutput("valid_err_same_cycle", 1, 0);
            if (err) obs_errs++;
            if (num_valid) begin
                rep_t e;
                obs_valids++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("report", {1'b0, num, en, dp}, {1'b0, e});
                end
            end
        end
    end

    task automatic doReset();
        rst     = 1'b1;
        seg_sel = 6'h3F;
        seg_led = 8'hFF;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        seg_sel = 6'h3F;
        seg_led = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic [7:0] pat);
        logic [5:0] one;
        one     = 6'b1;
        seg_sel = ~(one << k);
        seg_led = pat;
        modelCapture(k, pat);
        repeat (DIGIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic scanFrame(input logic [47:0] pats);
        for (int k = 0; k < 6; k++) applyStimulus(k, pats[8*k +: 8]);
    endtask

    function automatic logic [7:0] randPattern();
        int         r;
        logic [6:0] p;
        r = $urandom_range(0, 39);
        if (r < 30)      p = seg_tab[r % 10];
        else if (r < 34) p = seg_tab[10 + $urandom_range(0, 5)];
        else if (r < 38) p = 7'h7F;
        else             p = 7'($urandom);
        return {($urandom_range(0, 3) != 0), p};
    endfunction

    vec_t        vecs[5];
    logic [47:0] cur;
    logic [7:0]  pat;

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vecs[0] = '{48'hF9A4B0999282, 2, 1, 24'h123456, 1'b1, 6'h00, 0, 1'b0};
        vecs[1] = '{48'hC0C0FFC0C0C0, 2, 1, 24'h000000, 1'b1, 6'h00, 0, 1'b0};
        vecs[2] = '{48'hFFFFFFFFFFFF, 2, 1, 24'h000000, 1'b0, 6'h00, 0, 1'b0};
        vecs[3] = '{48'hC0C0C0C079C0, 3, 2, 24'h000010, 1'b1, 6'h02, 0, 1'b0};
`ifdef SEG_DEC_HEX_EN
        vecs[4] = '{48'hC088C0C0C0C0, 2, 1, 24'h0A0000, 1'b1, 6'h00, 0, 1'b0};
`else
        vecs[4] = '{48'hC088C0C0C0C0, 2, 0, 24'h000000, 1'b0, 6'h00, 2, 1'b1};
`endif

        doReset();
        checkOutput("reset_num", num, 0);
        checkOutput("reset_en", en, 0);
        checkOutput("reset_dp", dp, 0);
        checkOutput("reset_stale", stale, 1);
        checkOutput("reset_valid", num_valid, 0);
        checkOutput("reset_err", err, 0);

        for (int i = 0; i < 5; i++) begin
            doReset();
            for (int f = 0; f < vecs[i].frames; f++) scanFrame(vecs[i].pats);
            checkOutput($sformatf("vec%0d_valids", i), obs_valids, vecs[i].exp_valids);
            checkOutput($sformatf("vec%0d_num", i), num, vecs[i].exp_num);
            checkOutput($sformatf("vec%0d_en", i), en, vecs[i].exp_en);
            checkOutput($sformatf("vec%0d_dp", i), dp, vecs[i].exp_dp);
            checkOutput($sformatf("vec%0d_errs", i), obs_errs, vecs[i].exp_errs);
            checkOutput($sformatf("vec%0d_stale", i), stale, vecs[i].exp_stale);
            checkOutput($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end

        // Changing frames restart the match count.
        doReset();
        scanFrame(48'hC0C0C0C0C0F9);
        scanFrame(48'hC0C0C0C0C0A4);
        checkOutput("chg_valids_early", obs_valids, 0);
        scanFrame(48'hC0C0C0C0C0A4);
        checkOutput("chg_valids", obs_valids, 1);
        checkOutput("chg_num", num, 24'h000002);

        // Illegal pattern on digit 2 drops that digit and restarts matching.
        doReset();
        repeat (3) scanFrame(48'hF9F9F9F9F9F9);
        checkOutput("bad_valids_before", obs_valids, 2);
        scanFrame(48'hF9F9F9FEF9F9);
        checkOutput("bad_valids_during", obs_valids, 2);
        checkOutput("bad_errs", obs_errs, 1);
        scanFrame(48'hF9F9F9F9F9F9);
        checkOutput("bad_valids_after1", obs_valids, 2);
        scanFrame(48'hF9F9F9F9F9F9);
        checkOutput("bad_valids_after2", obs_valids, 3);
        checkOutput("bad_num", num, 24'h111111);
        checkOutput("bad_pending", exp_q.size(), 0);

        // Timeout after the scan stops.
        doReset();
        repeat (2) scanFrame(vecs[0].pats);
        checkOutput("tmo_stale_before", stale, 0);
        idleCycles(900);
        checkOutput("tmo_stale_early", stale, 0);
        idleCycles(120);
        modelTimeout();
        checkOutput("tmo_stale", stale, 1);
        checkOutput("tmo_num_kept", num, 24'h123456);
        scanFrame(vecs[0].pats);
        checkOutput("tmo_valids_one_frame", obs_valids, 1);
        checkOutput("tmo_stale_still", stale, 1);
        scanFrame(vecs[0].pats);
        checkOutput("tmo_valids_recover", obs_valids, 2);
        checkOutput("tmo_stale_cleared", stale, 0);

        // Asynchronous reset in the middle of a settle window.
        doReset();
        repeat (2) scanFrame(vecs[0].pats);
        seg_sel = 6'h3E;
        seg_led = 8'h82;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_num", num, 0);
        checkOutput("arst_en", en, 0);
        checkOutput("arst_dp", dp, 0);
        checkOutput("arst_valid", num_valid, 0);
        checkOutput("arst_err", err, 0);
        checkOutput("arst_stale", stale, 1);

        // Randomized scans with repeats, glitches and inter-digit gaps.
        doReset();
        for (int k = 0; k < 6; k++) cur[8*k +: 8] = randPattern();
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < 6; k++) cur[8*k +: 8] = randPattern();
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 9) == 0) idleCycles(3);
                pat = cur[8*k +: 8];
                if ($urandom_range(0, 29) == 0) pat = 8'($urandom);
                applyStimulus(k, pat);
            end
        end
        checkOutput("rand_valids", obs_valids, m_valids);
        checkOutput("rand_errs", obs_errs, m_errs);
        checkOutput("rand_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule
